// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell with a registered borrow,
// processing a - b LSB first over WIDTH cycles behind a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             borrow_q, borrow_d;

    logic             d_bit;
    logic             bor_nxt;
    logic [WIDTH-1:0] res_cat;

    assign d_bit   = a_q[0] ^ b_q[0] ^ bor_q;
    assign bor_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bor_q);
    // The newest bit goes straight to the MSB, so the partial result needs only WIDTH-1 bits.
    assign res_cat = {d_bit, res_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = a;
                    b_d     = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_cat[WIDTH-1:1];
                bor_d = bor_nxt;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    diff_d   = res_cat;
                    borrow_d = bor_nxt;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 handshake/timing/reset cases plus an
// exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow_out;
    logic [7:0] diff;

    logic       start4;
    logic [3:0] a4, b4;
    logic       busy4, done4, borrow4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;
    logic [7:0] held_diff;
    logic       held_bor;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 op: result must appear exactly 8 edges after the accept, old result held.
    task automatic run_op(input logic [7:0] xa, input logic [7:0] xb, input string tag);
        logic [8:0] full;
        full  = {1'b0, xa} - {1'b0, xb};
        a     = xa;
        b     = xb;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~xa;
        b     = ~xb;
        for (int k = 1; k < 8; k++) begin
            chk({tag, " busy_run"}, busy, 1);
            chk({tag, " done_early"}, done, 0);
            chk({tag, " diff_held"}, diff, held_diff);
            chk({tag, " bor_held"}, borrow_out, held_bor);
            tick();
        end
        tick();
        chk({tag, " done"}, done, 1);
        chk({tag, " diff"}, diff, full[7:0]);
        chk({tag, " borrow"}, borrow_out, full[8]);
        tick();
        chk({tag, " done_clr"}, done, 0);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " diff_after"}, diff, full[7:0]);
        held_diff = full[7:0];
        held_bor  = full[8];
    endtask

    initial begin
        logic [7:0] pa, pb;
        logic [8:0] pfull;
        logic [4:0] f4;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        held_diff = '0; held_bor = 1'b0;
        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst diff", diff, 0);
        chk("rst borrow", borrow_out, 0);
        rst = 1'b0;
        tick();

        run_op(8'h5A, 8'h23, "5a-23");
        run_op(8'h00, 8'h01, "00-01");
        run_op(8'hFF, 8'hFF, "ff-ff");
        run_op(8'h80, 8'h7F, "80-7f");
        run_op(8'h5A, 8'h23, "5a-23b");
        run_op(8'h01, 8'h02, "01-02 held");

        // start held high with operands changing every cycle: accepts land on cycles 0, 10, 20
        pa = '0; pb = '0;
        start = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            a = 8'(cyc * 37 + 5);
            b = 8'(cyc * 91 + 3);
            if (cyc % 10 == 0) begin
                pa = a;
                pb = b;
            end
            tick();
            chk("stream done", done, (cyc % 10 == 8) ? 1 : 0);
            if (cyc % 10 == 8) begin
                pfull = {1'b0, pa} - {1'b0, pb};
                chk("stream diff", diff, pfull[7:0]);
                chk("stream borrow", borrow_out, pfull[8]);
                held_diff = pfull[7:0];
                held_bor  = pfull[8];
            end
        end
        start = 1'b0;
        tick();

        // asynchronous reset 4 cycles into RUN
        a = 8'h10; b = 8'h20; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre-rst busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst diff", diff, 0);
        chk("arst borrow", borrow_out, 0);
        #1 rst = 1'b0;
        tick();
        chk("post-rst idle", busy, 0);
        held_diff = '0; held_bor = 1'b0;
        run_op(8'h09, 8'h04, "09-04");

        // exhaustive WIDTH=4 sweep
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a4 = 4'(i);
                b4 = 4'(j);
                f4 = {1'b0, a4} - {1'b0, b4};
                start4 = 1'b1;
                tick();
                start4 = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    tick();
                    chk("w4 done", done4, (k == 4) ? 1 : 0);
                end
                chk("w4 diff", diff4, f4[3:0]);
                chk("w4 borrow", borrow4, f4[4]);
                tick();
                chk("w4 single pulse", done4, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
